// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchroniser, start-bit qualification at mid-bit,
// LSB-first mid-bit sampling. Optional parity stage under `UART_RX_PARITY_EN.
module uart_rx #(
  parameter int Data_bits  = 8,
  parameter int Oversample = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit Odd_parity = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_tick,
  input  logic                 rx,
  output logic [Data_bits-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 rx_busy
);

  localparam int SW = $clog2(Oversample);
  localparam int BW = $clog2(Data_bits + 1);
  localparam logic [SW-1:0] HalfLast = SW'(Oversample / 2 - 1);
  localparam logic [SW-1:0] BitLast  = SW'(Oversample - 1);
  localparam logic [BW-1:0] DataLast = BW'(Data_bits - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t                 r_state, w_state_nxt;
  logic [1:0]             r_sync;
  logic [SW-1:0]          r_cnt, w_cnt_nxt;
  logic [BW-1:0]          r_bits, w_bits_nxt;
  logic [Data_bits-1:0]   r_shift, w_shift_nxt;
  logic [Data_bits-1:0]   r_data;
  logic                   r_valid, r_ferr;
  logic                   w_rx_s, w_bit_end, w_done;
`ifdef UART_RX_PARITY_EN
  logic                   r_par, w_par_nxt, r_perr;
`endif

  assign w_rx_s    = r_sync[1];
  assign w_bit_end = (r_cnt == BitLast);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bits_nxt  = r_bits;
    w_shift_nxt = r_shift;
    w_done      = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    if (rx_tick) begin
      unique case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            w_state_nxt = S_START;
            w_cnt_nxt   = '0;
          end
        end
        S_START: begin
          // A start bit must still be low at its midpoint, otherwise it was a glitch.
          if (r_cnt == HalfLast) begin
            w_cnt_nxt  = '0;
            w_bits_nxt = '0;
            w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            w_shift_nxt = {w_rx_s, r_shift[Data_bits-1:1]};
            w_cnt_nxt   = '0;
            w_bits_nxt  = r_bits + 1'b1;
            if (r_bits == DataLast) begin
`ifdef UART_RX_PARITY_EN
              w_state_nxt = S_PARITY;
`else
              w_state_nxt = S_STOP;
`endif
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            w_par_nxt   = w_rx_s;
            w_cnt_nxt   = '0;
            w_state_nxt = S_STOP;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (w_bit_end) begin
            w_done      = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_bits  <= '0;
      r_shift <= '0;
`ifdef UART_RX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_sync  <= {r_sync[0], rx};
      r_cnt   <= w_cnt_nxt;
      r_bits  <= w_bits_nxt;
      r_shift <= w_shift_nxt;
`ifdef UART_RX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  // Delivery registers: valid is a one-cycle pulse, data and error flags hold until the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr  <= 1'b0;
`endif
    end else begin
      r_valid <= w_done;
      if (w_done) begin
        r_data <= r_shift;
        r_ferr <= ~w_rx_s;
`ifdef UART_RX_PARITY_EN
        r_perr <= ((^r_shift) ^ r_par) != Odd_parity;
`endif
      end
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign rx_busy   = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_perr;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a frame driver pushes expected words, a monitor
// pops and compares on every rx_valid pulse. Directed cases, then random frames.
module tb_uart_rx;

  localparam int DB       = 8;
  localparam int OS       = 16;
  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = OS * TICK_DIV;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME_BITS = 1 + DB + PAR + 1;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          rx_tick;
  logic          rx    = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_valid, frame_err, rx_busy;
`ifdef UART_RX_PARITY_EN
  logic          parity_err;
`endif

  typedef struct {
    logic [DB-1:0] data;
    logic          ferr;
    logic          perr;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   last_valid_cyc = -1;
  logic prev_valid = 1'b0;

  uart_rx #(.Data_bits(DB), .Oversample(OS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_tick   (rx_tick),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    rx_tick = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(negedge clk);
      rx_tick = 1'b1;
      @(negedge clk);
      rx_tick = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Reference: data as sent, frame error = stop bit low, parity error = bad parity bit sent.
  task automatic send_frame(input logic [DB-1:0] data, input logic stop_bit, input logic par_good);
    exp_t e;
    e.data = data;
    e.ferr = ~stop_bit;
    e.perr = ~par_good;
    sb.push_back(e);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rx = data[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = par_good ? (^data) : ~(^data);
    repeat (BIT_CLKS) @(negedge clk);
`endif
    rx = stop_bit;
    repeat (BIT_CLKS) @(negedge clk);
    rx = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rx_valid) begin
      check("valid_pulse_width", prev_valid, 1'b0);
      last_valid_cyc = cyc;
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_valid: rx_data=%0h with no frame pending", rx_data);
      end else begin
        e = sb.pop_front();
        check("rx_data", rx_data, e.data);
        check("frame_err", frame_err, e.ferr);
`ifdef UART_RX_PARITY_EN
        check("parity_err", parity_err, e.perr);
`endif
      end
    end
    prev_valid = rx_valid;
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int lat;
    logic [DB-1:0] d;
    logic stop_b, pg;

    #1 rst_n = 1'b0;
    #22;
    check("reset_rx_data", rx_data, '0);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_rx_busy", rx_busy, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    idle(20);

    t0 = cyc;
    send_frame(8'hA5, 1'b1, 1'b1);
    lat = last_valid_cyc - t0;
    check("valid_latency_in_window", (lat >= 600 + PAR * BIT_CLKS && lat <= 625 + PAR * BIT_CLKS), 1);
    idle(10);

    send_frame(8'h3C, 1'b0, 1'b1);
    idle(2 * BIT_CLKS);
    send_frame(8'h11, 1'b1, 1'b1);
    idle(10);

    rx = 1'b0;
    repeat (15) @(negedge clk);
    check("glitch_busy_high", rx_busy, 1'b1);
    repeat (5) @(negedge clk);
    idle(40);
    check("glitch_busy_cleared", rx_busy, 1'b0);
    idle(BIT_CLKS);

    // Break: line low for most of the stop bit yields one all-zero frame with frame error.
    begin
      exp_t e;
      e.data = '0; e.ferr = 1'b1; e.perr = 1'b0;
      sb.push_back(e);
    end
    rx = 1'b0;
    repeat ((FRAME_BITS - 1) * BIT_CLKS + BIT_CLKS * 3 / 4) @(negedge clk);
    idle(3 * BIT_CLKS);

    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    idle(10);

    d = 8'h5A;
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = d[4];
    repeat (BIT_CLKS / 2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midframe_reset_rx_data", rx_data, '0);
    check("midframe_reset_rx_busy", rx_busy, 1'b0);
    check("midframe_reset_valid", rx_valid, 1'b0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2 * BIT_CLKS);
    check("post_reset_rx_data_held", rx_data, '0);
    check("post_reset_idle", rx_busy, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b1);
    idle(10);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    idle(10);
    send_frame(8'h07, 1'b1, 1'b0);
    idle(10);
`endif

    for (int n = 0; n < 20; n++) begin
      d      = DB'($urandom);
      stop_b = ($urandom_range(0, 3) != 0);
      pg     = (PAR == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      send_frame(d, stop_b, pg);
      if (stop_b) idle($urandom_range(0, 80));
      else idle(2 * BIT_CLKS + $urandom_range(0, 40));
    end

    idle(2 * BIT_CLKS);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
